// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared sizes and FSM state type for the round-robin mux arbiter.
package mux_arb_pkg;
    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;
    typedef enum logic {IDLE, BUSY} state_t;
endpackage

// File: rtl/rr_mux_arb8_mux8.sv
// mux8: 8:1 single-bit data selector.
module mux8 (
    input  logic [7:0] d,
    input  logic [2:0] s,
    output logic       y
);
    assign y = d[s];
endmodule

// File: rtl/rr_mux_arb8.sv
// rr_mux_arb8: 8-channel round-robin arbiter with registered 1-bit data mux and valid/ready output.
// Optional sticky grant via `RR_MUX_ARB8_LOCK_EN (adds the lock input).
module rr_mux_arb8
    import mux_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    input  logic [NUM_CH-1:0] d,
`ifdef RR_MUX_ARB8_LOCK_EN
    input  logic [NUM_CH-1:0] lock,
`endif
    input  logic              y_ready,
    output logic              y,
    output logic              y_valid,
    output logic [SEL_W-1:0]  s,
    output logic [NUM_CH-1:0] grant,
    output logic [NUM_CH-1:0] ack
);
    state_t            r_state;
    logic [SEL_W-1:0]  r_s;
    logic [SEL_W-1:0]  r_ptr;
    logic              r_y;
    logic              w_hs;
    logic              w_keep;
    logic              w_any;
    logic              w_mux_y;
    logic [SEL_W-1:0]  w_base;
    logic [SEL_W-1:0]  w_win;
    logic [SEL_W-1:0]  w_idx;
    logic [SEL_W-1:0]  w_next;
    logic [NUM_CH-1:0] w_req;

    assign w_hs = (r_state == BUSY) && y_ready;
`ifdef RR_MUX_ARB8_LOCK_EN
    assign w_keep = w_hs && lock[r_s] && req[r_s];
`else
    assign w_keep = 1'b0;
`endif
    // On handshake the search restarts after the channel just served, which is masked out.
    assign w_base = w_hs ? r_s : r_ptr;
    assign w_req  = w_hs ? (req & ~(NUM_CH'(1) << r_s)) : req;
    assign w_any  = |w_req;

    always_comb begin
        w_win = '0;
        w_idx = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            w_idx = w_base + SEL_W'(k);
            if (w_req[w_idx]) w_win = w_idx;
        end
    end

    assign w_next = w_keep ? r_s : w_win;

    mux8 u_mux (.d(d), .s(w_next), .y(w_mux_y));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_s     <= '0;
            r_y     <= 1'b0;
            r_ptr   <= SEL_W'(NUM_CH - 1);
        end else if (r_state == IDLE || w_hs) begin
            if (w_hs && !w_keep) r_ptr <= r_s;
            if (w_keep || w_any) begin
                r_s     <= w_next;
                r_y     <= w_mux_y;
                r_state <= BUSY;
            end else begin
                r_state <= IDLE;
            end
        end
    end

    assign y       = r_y;
    assign y_valid = (r_state == BUSY);
    assign s       = r_s;
    assign grant   = y_valid ? (NUM_CH'(1) << r_s) : '0;
    assign ack     = w_hs ? grant : '0;
endmodule

// File: tb/tb_rr_mux_arb8.sv
// tb_rr_mux_arb8: directed self-checking bench for rr_mux_arb8.
// Observed vector is {y_valid, s, y, grant, ack}.
module tb_rr_mux_arb8;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] d;
    logic       y_ready;
    logic       y;
    logic       y_valid;
    logic [2:0] s;
    logic [7:0] grant;
    logic [7:0] ack;
`ifdef RR_MUX_ARB8_LOCK_EN
    logic [7:0] lock = 8'h00;
`endif
    int total = 0;
    int bad = 0;
    wire [20:0] obs = {y_valid, s, y, grant, ack};

    rr_mux_arb8 dut (
        .clk(clk), .rst_n(rst_n), .req(req), .d(d),
`ifdef RR_MUX_ARB8_LOCK_EN
        .lock(lock),
`endif
        .y_ready(y_ready), .y(y), .y_valid(y_valid), .s(s), .grant(grant), .ack(ack)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = 8'h00;
        d = 8'h00;
        y_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = 8'hFF;
        d = 8'hFF;
        y_ready = 1'b1;
        #2;
        total++;
        if (obs !== 21'h0) begin
            bad++;
            $display("FAIL reset_async: got %h want %h", obs, 21'h0);
        end
        tick();
        total++;
        if (obs !== 21'h0) begin
            bad++;
            $display("FAIL reset_held: got %h want %h", obs, 21'h0);
        end
        req = 8'h00;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_single();
        do_reset();
        req = 8'h01;
        d = 8'h01;
        y_ready = 1'b1;
        #1;
        total++;
        if (obs !== 21'h0) begin
            bad++;
            $display("FAIL single_pre: got %h want %h", obs, 21'h0);
        end
        tick();
        total++;
        if (obs !== {1'b1, 3'd0, 1'b1, 8'h01, 8'h01}) begin
            bad++;
            $display("FAIL single_grant: got %h want %h", obs, {1'b1, 3'd0, 1'b1, 8'h01, 8'h01});
        end
        req = 8'h00;
        tick();
        total++;
        if ({y_valid, grant, ack} !== 17'h0) begin
            bad++;
            $display("FAIL single_idle: got %h want %h", {y_valid, grant, ack}, 17'h0);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] pat;
        logic [2:0] es;
        pat = 8'hA5;
        do_reset();
        req = 8'hFF;
        d = pat;
        y_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            es = 3'(i);
            total++;
            if (obs !== {1'b1, es, pat[es], 8'h01 << es, 8'h01 << es}) begin
                bad++;
                $display("FAIL rr_step%0d: got %h want %h", i, obs, {1'b1, es, pat[es], 8'h01 << es, 8'h01 << es});
            end
        end
        req = 8'h00;
        tick();
        total++;
        if (y_valid !== 1'b0) begin
            bad++;
            $display("FAIL rr_drain: got %b want 0", y_valid);
        end
    endtask

    task automatic test_hold();
        do_reset();
        req = 8'h10;
        y_ready = 1'b1;
        tick();
        req = 8'h00;
        tick();
        req = 8'h90;
        d = 8'h80;
        tick();
        total++;
        if (obs !== {1'b1, 3'd7, 1'b1, 8'h80, 8'h80}) begin
            bad++;
            $display("FAIL hold_first: got %h want %h", obs, {1'b1, 3'd7, 1'b1, 8'h80, 8'h80});
        end
        req = 8'h10;
        tick();
        y_ready = 1'b0;
        #1;
        total++;
        if (obs !== {1'b1, 3'd4, 1'b0, 8'h10, 8'h00}) begin
            bad++;
            $display("FAIL hold_second: got %h want %h", obs, {1'b1, 3'd4, 1'b0, 8'h10, 8'h00});
        end
        for (int i = 0; i < 5; i++) begin
            d = ~d;
            req = (i % 2 == 0) ? 8'h00 : 8'hFF;
            tick();
            total++;
            if (obs !== {1'b1, 3'd4, 1'b0, 8'h10, 8'h00}) begin
                bad++;
                $display("FAIL hold_cycle%0d: got %h want %h", i, obs, {1'b1, 3'd4, 1'b0, 8'h10, 8'h00});
            end
        end
        req = 8'h00;
        y_ready = 1'b1;
        #1;
        total++;
        if (ack !== 8'h10) begin
            bad++;
            $display("FAIL hold_ack: got %h want %h", ack, 8'h10);
        end
        tick();
    endtask

    task automatic test_drop();
        req = 8'h08;
        d = 8'h08;
        y_ready = 1'b0;
        tick();
        total++;
        if (obs !== {1'b1, 3'd3, 1'b1, 8'h08, 8'h00}) begin
            bad++;
            $display("FAIL drop_grant: got %h want %h", obs, {1'b1, 3'd3, 1'b1, 8'h08, 8'h00});
        end
        req = 8'h00;
        d = 8'h00;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (obs !== {1'b1, 3'd3, 1'b1, 8'h08, 8'h00}) begin
                bad++;
                $display("FAIL drop_wait%0d: got %h want %h", i, obs, {1'b1, 3'd3, 1'b1, 8'h08, 8'h00});
            end
        end
        y_ready = 1'b1;
        #1;
        total++;
        if (ack !== 8'h08) begin
            bad++;
            $display("FAIL drop_ack: got %h want %h", ack, 8'h08);
        end
        tick();
        total++;
        if ({y_valid, ack} !== 9'h0) begin
            bad++;
            $display("FAIL drop_idle: got %h want %h", {y_valid, ack}, 9'h0);
        end
    endtask

    task automatic test_reset_mid();
        req = 8'h20;
        d = 8'h20;
        y_ready = 1'b0;
        tick();
        total++;
        if (obs !== {1'b1, 3'd5, 1'b1, 8'h20, 8'h00}) begin
            bad++;
            $display("FAIL midrst_grant: got %h want %h", obs, {1'b1, 3'd5, 1'b1, 8'h20, 8'h00});
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (obs !== 21'h0) begin
            bad++;
            $display("FAIL midrst_async: got %h want %h", obs, 21'h0);
        end
        req = 8'h21;
        d = 8'h01;
        tick();
        rst_n = 1'b1;
        tick();
        total++;
        if (obs !== {1'b1, 3'd0, 1'b1, 8'h01, 8'h00}) begin
            bad++;
            $display("FAIL midrst_first: got %h want %h", obs, {1'b1, 3'd0, 1'b1, 8'h01, 8'h00});
        end
        d = 8'h00;
        y_ready = 1'b1;
        tick();
        total++;
        if (obs !== {1'b1, 3'd5, 1'b0, 8'h20, 8'h20}) begin
            bad++;
            $display("FAIL midrst_second: got %h want %h", obs, {1'b1, 3'd5, 1'b0, 8'h20, 8'h20});
        end
        req = 8'h00;
        tick();
    endtask

`ifdef RR_MUX_ARB8_LOCK_EN
    task automatic test_lock();
        do_reset();
        lock = 8'h04;
        req = 8'h0C;
        d = 8'h04;
        y_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (obs !== {1'b1, 3'd2, 1'b1, 8'h04, 8'h04}) begin
                bad++;
                $display("FAIL lock_hold%0d: got %h want %h", i, obs, {1'b1, 3'd2, 1'b1, 8'h04, 8'h04});
            end
        end
        lock = 8'h00;
        tick();
        total++;
        if (obs !== {1'b1, 3'd3, 1'b0, 8'h08, 8'h08}) begin
            bad++;
            $display("FAIL lock_release: got %h want %h", obs, {1'b1, 3'd3, 1'b0, 8'h08, 8'h08});
        end
        req = 8'h00;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_hold();
        test_drop();
        test_reset_mid();
`ifdef RR_MUX_ARB8_LOCK_EN
        test_lock();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rr_mux_arb8.md
RR_MUX_ARB8 -- requirements
Module: rr_mux_arb8

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have the port req, input, 8 bits: request per channel; bit i requests transfer of d[i].
REQ-004 The block SHALL have the port d, input, 8 bits: data bit per channel.
REQ-005 The block SHALL have the port y_ready, input, 1 bit: downstream accepts y this cycle.
REQ-006 The block SHALL have the port y, output, 1 bit: data bit of the granted channel, registered.
REQ-007 The block SHALL have the port y_valid, output, 1 bit: y holds a pending transfer.
REQ-008 The block SHALL have the port s, output, 3 bits: index of the granted channel (mux select).
REQ-009 The block SHALL have the port grant, output, 8 bits: one-hot grant, equal to 1<<s while y_valid, else 0.
REQ-010 The block SHALL have the port ack, output, 8 bits: one-cycle one-hot pulse on the channel whose transfer completed.
REQ-011 With LOCK_EN defined, the block SHALL have the port lock, input, 8 bits: channel i requests to keep its grant after a transfer.

Function
REQ-012 The FSM SHALL have two states, IDLE and BUSY; y_valid SHALL be 1 exactly in BUSY.
REQ-013 In IDLE with req!=0, the block SHALL select the first set req bit searching upward from ptr+1 (mod 8), load s, and capture y<=d[winner]; the next state is BUSY. Latency is 1 cycle from req to y_valid.
REQ-014 In BUSY, y and s SHALL stay stable regardless of changes on d or req; deassertion of the granted req SHALL NOT cancel the transfer.
REQ-015 A handshake SHALL occur when y_valid && y_ready; in that cycle ack[s]=1 and ptr<=s.
REQ-016 On handshake, if any req bit other than s is set, the block SHALL arbitrate the next winner in the same cycle, searching from s+1 with bit s masked, and stay in BUSY (one transfer per cycle sustained); otherwise it SHALL go to IDLE.
REQ-017 A requester SHALL drop req the cycle after its ack; if req is still high, it re-arbitrates at lowest priority.
REQ-018 In BUSY with y_ready=0, all outputs SHALL hold indefinitely (no timeout).
REQ-019 ptr SHALL wrap 7->0; the search SHALL be a pure modulo-8 rotation with no priority bias.

Reset
REQ-020 On rst_n low, the block SHALL set state=IDLE, s=0, y=0, y_valid=0, grant=0, ack=0, and ptr=7 (so channel 0 has first priority), asynchronously.
REQ-021 Reset mid-BUSY SHALL abort the transfer with no ack issued; after release, arbitration restarts from channel 0.

Configuration
REQ-022 With macro RR_MUX_ARB8_LOCK_EN defined: on handshake, if lock[s]=1 and req[s]=1, the grant SHALL stay on s (new y<=d[s], ptr unchanged) instead of rotating. Without the macro: no lock port, and behaviour is pure round-robin per REQ-016.

Structure
REQ-023 Package mux_arb_pkg SHALL hold NUM_CH=8, SEL_W=3, and the state enum {IDLE, BUSY}.
REQ-024 Data selection SHALL instantiate sub-module mux8 (d, s, y) driven by the next-winner index; the rotating priority search SHALL be inline combinational logic.

Verification
REQ-025 After reset, req=8'h01, d=8'h01, y_ready=1: y_valid=1 with s=0 and y=1 the next cycle, then ack=8'h01.
REQ-026 With req=8'hFF held and y_ready=1: grant order SHALL be 0,1,...,7,0 on consecutive cycles with y_valid constantly 1.
REQ-027 With req=8'h90 and ptr=4: grant SHALL go to 7 and then 4; d toggled during BUSY with y_ready=0 SHALL leave y unchanged for 5 cycles.
REQ-028 Granting channel 3 and then dropping req[3] while y_ready=0: the transfer SHALL still complete with ack=8'h08 when y_ready rises.
REQ-029 Asserting rst_n=0 mid-BUSY on channel 5: all outputs SHALL be 0 immediately; after release with req=8'h21, channel 0 SHALL be granted first.
REQ-030 With LOCK_EN, lock=8'h04 and req=8'h0C: channel 2 SHALL be granted repeatedly; after lock drops, channel 3 SHALL follow.
